// File: rtl/cpu_mem_pkg.sv
// Shared encodings and helpers for the CPU data-memory port.
// Used by the responder FSM and the byte-lane aligner.
package cpu_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic access_err(
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic [31:0] limit
    );
        return (size == 2'b11)
            | ((size == SZ_HALF) & addr[0])
            | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
            | (addr >= limit);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RISC-V loads and stores on a 32-bit word.
// Produces the merged store word, lane enables and the extended load value.
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] st_word,
    output logic [3:0]  be,
    output logic [31:0] ld_data
);

    logic [31:0] rep;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        be      = 4'b0000;
        rep     = wdata;
        ld_data = 32'h0;
        st_word = old_word;
        ld_b    = old_word[{lane, 3'b000} +: 8];
        ld_h    = lane[1] ? old_word[31:16] : old_word[15:0];
        unique case (1'b1)
            (size == SZ_BYTE): begin
                be      = 4'b0001 << lane;
                rep     = {4{wdata[7:0]}};
                ld_data = is_unsigned ? {24'h0, ld_b}
                                      : {{24{ld_b[7]}}, ld_b};
            end
            (size == SZ_HALF): begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                rep     = {2{wdata[15:0]}};
                ld_data = is_unsigned ? {16'h0, ld_h}
                                      : {{16{ld_h[15]}}, ld_h};
            end
            (size == SZ_WORD): begin
                be      = 4'b1111;
                ld_data = old_word;
            end
            default: begin
                be      = 4'b0000;
                ld_data = 32'h0;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (be[i]) st_word[8*i +: 8] = rep[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the CPU load/store port with fixed wait states.
// One request in flight; the response is held until the requester takes it.
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT    = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_LAST =
        4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;

    logic [31:0] mem [DEPTH_WORDS];

    logic        acc_write;
    logic        acc_unsigned;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [1:0]  acc_size;
    logic        acc_err;
    logic        do_acc;
    logic        mem_we;
    logic [AW-1:0] word_idx;
    logic [31:0] old_word;
    logic [31:0] st_word;
    logic [3:0]  be;
    logic [31:0] ld_data;

    // In IDLE the only access possible is the zero-wait one, which must
    // use the live request because the latches update on the same edge.
    always_comb begin
        acc_write    = lat_write;
        acc_unsigned = lat_unsigned;
        acc_addr     = lat_addr;
        acc_wdata    = lat_wdata;
        acc_size     = lat_size;
        if (state == IDLE) begin
            acc_write    = req_write;
            acc_unsigned = req_unsigned;
            acc_addr     = req_addr;
            acc_wdata    = req_wdata;
            acc_size     = req_size;
        end
    end

    assign acc_err  = access_err(acc_size, acc_addr, LIMIT);
    assign word_idx = acc_addr[AW+1:2];
    assign old_word = mem[word_idx];

    always_comb begin
        do_acc = 1'b0;
        if (WAIT_CYCLES == 0)
            do_acc = (state == IDLE) & req_valid;
        else
            do_acc = (state == WAIT) & (cnt == CNT_LAST);
    end

    assign mem_we = do_acc & acc_write & ~acc_err & (|be) & rst;

    mem_lane_align u_align (
        .size        (acc_size),
        .is_unsigned (acc_unsigned),
        .lane        (acc_addr[1:0]),
        .old_word    (old_word),
        .wdata       (acc_wdata),
        .st_word     (st_word),
        .be          (be),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk) begin
        if (mem_we) mem[word_idx] <= st_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
            rsp_err      <= 1'b0;
            lat_write    <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            lat_size     <= SZ_BYTE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write    <= req_write;
                        lat_unsigned <= req_unsigned;
                        lat_addr     <= req_addr;
                        lat_wdata    <= req_wdata;
                        lat_size     <= req_size;
                        cnt          <= 4'd0;
                        req_ready    <= 1'b0;
                        state        <= WAIT;
                        if (do_acc) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= acc_err;
                            rsp_rdata <= (acc_err | acc_write) ? 32'h0
                                                               : ld_data;
                            state     <= RESP;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (do_acc) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err | acc_write) ? 32'h0
                                                           : ld_data;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the CPU's load/store port over a valid/ready request/response handshake. It accepts one request at a time and models a configurable number of wait states before responding. It performs RISC-V byte/half/word store lane merging and load sign/zero extension internally. It sits between the CPU data path and the word-organised data array, and is the slave end of the CPU's memory interface.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1
- WAIT_CYCLES, 2: wait states between acceptance and response; legal range 0..15
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- req_valid  input  1  request present
- req_ready  output  1  responder can accept; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_size  input  2  funct3[1:0]: 00 byte, 01 half, 10 word; 11 illegal
- req_unsigned  input  1  funct3[2]: zero-extend load result
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester takes response
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  misaligned, out-of-range, or illegal-size request

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch write, addr, wdata, size, unsigned; clear wait counter.
  - WAIT_CYCLES>0: go to WAIT.
  - WAIT_CYCLES=0: perform access and go to RESP.
- WAIT: counter increments each cycle. On the edge where the counter reaches WAIT_CYCLES-1, perform the access and go to RESP.
- Access, evaluated on latched fields:
  - err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | (addr >= 4*DEPTH_WORDS).
  - Store without err: write only the addressed byte lanes of word addr[31:2]. Other lanes are unchanged.
  - Load without err: extract the lane and sign- or zero-extend it into rsp_rdata.
  - On err: memory is untouched, rsp_rdata=0, rsp_err=1.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are registered and held stable until rsp_ready. On rsp_ready, go to IDLE and clear rsp_err and rsp_rdata.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0. The memory array is not reset and its contents are undefined.
- Reset mid-operation: an accepted but not yet committed store (still in WAIT) is discarded. A store already committed stays committed. Any pending response is dropped.
- Request inputs are ignored outside IDLE. Changes to req_* after acceptance have no effect.

## Timing
- Acceptance edge E0 is the rising edge with req_valid & req_ready.
- Memory update and response capture happen at edge E(WAIT_CYCLES). rsp_valid is high from that edge. The zero-wait case is E0 itself: rsp_valid is high the cycle after acceptance.
- Minimum request spacing: WAIT_CYCLES+2 cycles. There is one IDLE cycle after each response handshake; no request is accepted during RESP.
- rsp_valid may stay high for any number of cycles; the response must not change while it does.
- Read-after-write: a load accepted after a store's response sees the stored data.

## Structure
- Shared package cpu_mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state enum {IDLE, WAIT, RESP}
- One combinational sub-module, mem_lane_align:
  - inputs: size, unsigned, addr[1:0], old word, wdata
  - outputs: merged store word, byte-enable[3:0], extended load value
- The FSM, counter and array live in dmem_responder.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10 with WAIT_CYCLES=2 → rsp_valid 3 cycles after acceptance, rdata 0xDEADBEEF, err 0.
- After the above, byte store 0x5A to 0x12, then loads:
  - word load 0x10 → 0xDE5ABEEF
  - lb 0x13 → 0xFFFFFFDE
  - lbu 0x13 → 0x000000DE
  - lh 0x10 → 0xFFFFBEEF
- Misalignment and range, with 0x10 still 0xDE5ABEEF:
  - half store to 0x11 → err 1, memory unchanged (word load 0x10 still 0xDE5ABEEF)
  - word load at 4*DEPTH_WORDS → err 1, rdata 0
  - req_size=11 → err 1
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid, rdata and err stable, req_ready=0. A new req_valid during this time is not accepted.
- Reset: drop rst during WAIT of a store to 0x20 (previously 0x11111111) → outputs return to reset values and a later load of 0x20 returns 0x11111111.
- WAIT_CYCLES=0 instance: back-to-back store/load are each accepted one cycle after the prior response handshake, and rsp_valid comes one cycle after acceptance.
